reg_bank_write_ctrl: RTL and testbench

//  Write-port controller for the register bank built from per-register flip-flops in the single-cycle RISC-V core.

---
 rtl/reg_bank_write_ctrl_pkg.sv | 22 ++
 rtl/reg_bank_write_ctrl_if.sv | 30 +++
 rtl/reg_bank_write_ctrl_rr_arbiter2.sv | 34 +++
 rtl/reg_bank_write_ctrl.sv | 134 +++++++++++++
 tb/tb_reg_bank_write_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_write_ctrl_pkg.sv
// Shared definitions for the register-bank write controller: FSM state
// encoding, requester indices and the one-hot register-select decoder.
package reg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Widest bank the decoder supports; callers truncate to their own width.
    localparam int MAX_REGS = 256;

    function automatic logic [MAX_REGS-1:0] onehot_decode(input logic [7:0] idx);
        onehot_decode      = '0;
        onehot_decode[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/reg_bank_write_ctrl_if.sv
// Requester handshakes plus the write bus into the per-register flip-flops.
// master = requesters and register bank side, slave = the write controller.
interface reg_bank_write_ctrl_if #(
    parameter int NrOfBits = 32,
    parameter int NrOfRegs = 32,
    parameter int AddrBits = 5
);
    logic                req0_valid;
    logic [AddrBits-1:0] req0_addr;
    logic [NrOfBits-1:0] req0_data;
    logic                req0_ready;
    logic                req1_valid;
    logic [AddrBits-1:0] req1_addr;
    logic [NrOfBits-1:0] req1_data;
    logic                req1_ready;
    logic [NrOfRegs-1:0] wr_en;
    logic [NrOfBits-1:0] wr_data;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready, wr_en, wr_data
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready, wr_en, wr_data
    );
endinterface

// File: rtl/reg_bank_write_ctrl_rr_arbiter2.sv
// Two-requester round-robin picker. On a tie the requester that did not win
// last time is chosen; last_grant only moves on Tick edges where the
// controller actually accepts a request (enable high).
module rr_arbiter2 (
    input  logic Clock,
    input  logic Reset,
    input  logic Tick,
    input  logic enable,
    input  logic req0,
    input  logic req1,
    output logic grant,
    output logic grant_valid
);
    logic last_grant;

    // Pick the winner for the current cycle.
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else begin
            grant = req1;
        end
    end

    // Remember who won so the other side gets the next tie.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_grant <= 1'b1;
        end else if (Tick && enable && grant_valid) begin
            last_grant <= grant;
        end
    end
endmodule

// File: rtl/reg_bank_write_ctrl.sv
// Write-port controller for the flip-flop register bank. Arbitrates core
// writeback and debug/loader writes, then drives a one-hot ClockEnable and
// shared write data for one Tick cycle. x0 is never written.
// Optional feature: define REGCTRL_CLEAR_SWEEP_EN to add a clear sweep that
// zeroes x1..x(NrOfRegs-1), one register per Tick cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting; samples clear_req / requesters on Tick edges
// ST_WRITE | latched write presented on wr_en/wr_data, ready pulses
// ST_SWEEP | clear sweep, writing zero to register sweep_ptr
module reg_bank_write_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int NrOfBits = 32,
    parameter int NrOfRegs = 32,
    parameter int AddrBits = 5
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Tick,
    input  logic clear_req,
    output logic busy,
    reg_bank_write_ctrl_if.slave bus
);
    state_t              state;
    logic [NrOfRegs-1:0] wr_sel_q;
    logic [NrOfBits-1:0] wr_data_q;
    logic [1:0]          rdy_sel_q;

    logic                grant;
    logic                grant_valid;
    logic                sweep_start;
    logic [AddrBits-1:0] win_addr;
    logic [NrOfBits-1:0] win_data;
    logic [NrOfRegs-1:0] win_onehot;

`ifdef REGCTRL_CLEAR_SWEEP_EN
    logic [AddrBits-1:0] sweep_ptr;
    logic [NrOfRegs-1:0] ptr_next_onehot;
    logic [NrOfRegs-1:0] ptr_first_onehot;

    assign sweep_start = clear_req;

    // Select bits for the next sweep target and for the first one (x1).
    always_comb begin
        ptr_next_onehot  = NrOfRegs'(onehot_decode(8'(sweep_ptr) + 8'd1));
        ptr_first_onehot = NrOfRegs'(onehot_decode(8'd1));
    end
`else
    logic unused_clear_req;

    assign sweep_start      = 1'b0;
    assign unused_clear_req = clear_req;
`endif

    rr_arbiter2 u_arb (
        .Clock       (Clock),
        .Reset       (Reset),
        .Tick        (Tick),
        .enable      ((state == ST_IDLE) && !sweep_start),
        .req0        (bus.req0_valid),
        .req1        (bus.req1_valid),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Steer the winning requester's address/data; bit 0 is masked so x0 stays hardwired.
    always_comb begin
        win_addr   = (grant == REQ1) ? bus.req1_addr : bus.req0_addr;
        win_data   = (grant == REQ1) ? bus.req1_data : bus.req0_data;
        win_onehot = NrOfRegs'(onehot_decode(8'(win_addr))) & ~NrOfRegs'(1);
    end

    // Controller FSM; every registered output is updated alongside the state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
            rdy_sel_q <= 2'b00;
`ifdef REGCTRL_CLEAR_SWEEP_EN
            sweep_ptr <= AddrBits'(1);
`endif
        end else if (Tick) begin
            case (state)
                ST_IDLE: begin
                    if (sweep_start) begin
`ifdef REGCTRL_CLEAR_SWEEP_EN
                        state     <= ST_SWEEP;
                        wr_sel_q  <= ptr_first_onehot;
                        wr_data_q <= '0;
`endif
                    end else if (grant_valid) begin
                        state     <= ST_WRITE;
                        wr_sel_q  <= win_onehot;
                        wr_data_q <= win_data;
                        rdy_sel_q <= (grant == REQ1) ? 2'b10 : 2'b01;
                    end
                end
                ST_WRITE: begin
                    state     <= ST_IDLE;
                    wr_sel_q  <= '0;
                    wr_data_q <= '0;
                    rdy_sel_q <= 2'b00;
                end
`ifdef REGCTRL_CLEAR_SWEEP_EN
                ST_SWEEP: begin
                    if (sweep_ptr == AddrBits'(NrOfRegs - 1)) begin
                        state     <= ST_IDLE;
                        wr_sel_q  <= '0;
                        sweep_ptr <= AddrBits'(1);
                    end else begin
                        wr_sel_q  <= ptr_next_onehot;
                        sweep_ptr <= sweep_ptr + AddrBits'(1);
                    end
                end
`endif
                default: begin
                    state     <= ST_IDLE;
                    wr_sel_q  <= '0;
                    wr_data_q <= '0;
                    rdy_sel_q <= 2'b00;
                end
            endcase
        end
    end

    assign bus.wr_en      = wr_sel_q & {NrOfRegs{Tick}};
    assign bus.wr_data    = wr_data_q;
    assign bus.req0_ready = rdy_sel_q[0] & Tick;
    assign bus.req1_ready = rdy_sel_q[1] & Tick;
    assign busy           = (state != ST_IDLE);
endmodule

// File: tb/tb_reg_bank_write_ctrl.sv
// Bench for reg_bank_write_ctrl: directed scenarios followed by random
// traffic, checked against a transaction-level model and a register-bank
// mirror. Honours REGCTRL_CLEAR_SWEEP_EN the same way as the design.
module tb_reg_bank_write_ctrl;
    localparam int NB = 32;
    localparam int NR = 32;
    localparam int AB = 5;

`ifdef REGCTRL_CLEAR_SWEEP_EN
    localparam bit SWEEP_ON = 1'b1;
`else
    localparam bit SWEEP_ON = 1'b0;
`endif

    localparam int MODE_IDLE  = 0;
    localparam int MODE_WRITE = 1;
    localparam int MODE_CLEAR = 2;

    logic Clock = 1'b0;
    logic Reset, Tick, clear_req, busy;

    reg_bank_write_ctrl_if #(.NrOfBits(NB), .NrOfRegs(NR), .AddrBits(AB)) bus ();

    reg_bank_write_ctrl #(.NrOfBits(NB), .NrOfRegs(NR), .AddrBits(AB)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Tick      (Tick),
        .clear_req (clear_req),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference model: what the controller is doing as a transaction.
    int          m_mode = MODE_IDLE;
    int          m_last = 1;
    int          m_who  = 0;
    int          m_addr = 0;
    logic [NB-1:0] m_data = '0;
    int          m_ptr  = 1;
    logic [NB-1:0] exp_bank  [NR];
    logic [NB-1:0] seen_bank [NR];
    int          grants[$];
    logic        got0, got1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        logic [NR-1:0] e_en;
        logic          e_r0, e_r1;
        int            g;
        @(negedge Clock);
        e_en = '0;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (m_mode == MODE_WRITE && Tick) begin
            if (m_addr != 0) e_en[m_addr] = 1'b1;
            if (m_who == 0) e_r0 = 1'b1; else e_r1 = 1'b1;
        end
        if (m_mode == MODE_CLEAR && Tick) e_en[m_ptr] = 1'b1;
        check_val("wr_en", bus.wr_en, e_en);
        check_val("req0_ready", bus.req0_ready, e_r0);
        check_val("req1_ready", bus.req1_ready, e_r1);
        check_val("busy", busy, m_mode != MODE_IDLE);
        check_val("onehot", $countones(bus.wr_en) <= 1, 1);
        if (m_mode == MODE_WRITE) check_val("wr_data", bus.wr_data, m_data);
        if (m_mode == MODE_CLEAR) check_val("sweep_data", bus.wr_data, 0);

        for (int i = 0; i < NR; i++)
            if (bus.wr_en[i]) seen_bank[i] = bus.wr_data;
        got0 = bus.req0_ready;
        got1 = bus.req1_ready;
        if (got0) grants.push_back(0);
        if (got1) grants.push_back(1);

        if (Reset) begin
            m_mode = MODE_IDLE;
            m_last = 1;
            m_ptr  = 1;
        end else if (Tick) begin
            case (m_mode)
                MODE_IDLE: begin
                    g = -1;
                    if (SWEEP_ON && clear_req) begin
                        m_mode = MODE_CLEAR;
                        m_ptr  = 1;
                    end else if (bus.req0_valid && bus.req1_valid) g = (m_last == 1) ? 0 : 1;
                    else if (bus.req0_valid) g = 0;
                    else if (bus.req1_valid) g = 1;
                    if (g >= 0) begin
                        m_mode = MODE_WRITE;
                        m_who  = g;
                        m_last = g;
                        m_addr = (g == 0) ? int'(bus.req0_addr) : int'(bus.req1_addr);
                        m_data = (g == 0) ? bus.req0_data : bus.req1_data;
                    end
                end
                MODE_WRITE: begin
                    if (m_addr != 0) exp_bank[m_addr] = m_data;
                    m_mode = MODE_IDLE;
                end
                default: begin
                    exp_bank[m_ptr] = '0;
                    if (m_ptr == NR - 1) begin
                        m_mode = MODE_IDLE;
                        m_ptr  = 1;
                    end else begin
                        m_ptr++;
                    end
                end
            endcase
        end
        @(posedge Clock);
        #1;
    endtask

    int exp_seq[4] = '{0, 1, 0, 1};
    logic [NR-1:0] walk;

    initial begin
        for (int i = 0; i < NR; i++) begin
            exp_bank[i]  = '0;
            seen_bank[i] = '0;
        end
        Reset = 1'b1; Tick = 1'b1; clear_req = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd4; bus.req0_data = $urandom;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd6; bus.req1_data = $urandom;
        @(posedge Clock);
        #1;

        // Reset held with both requesters pending
        repeat (3) cycle();
        check_val("rst_wr_data", bus.wr_data, 0);
        check_val("rst_wr_en", bus.wr_en, 0);

        // Single write from requester 0
        Reset = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_addr = 5'd5; bus.req0_data = 32'hDEADBEEF;
        cycle();
        check_val("t2_wr_en", bus.wr_en, 32'h0000_0020);
        check_val("t2_wr_data", bus.wr_data, 32'hDEADBEEF);
        check_val("t2_ready", bus.req0_ready, 1);
        cycle();
        bus.req0_valid = 1'b0;
        cycle();

        // Continuous contention alternates grants starting with requester 0
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        grants.delete();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = $urandom;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = $urandom;
        repeat (8) begin
            cycle();
            if (got0) bus.req0_data = $urandom;
            if (got1) bus.req1_data = $urandom;
        end
        check_val("t3_grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check_val("t3_grant_order", grants[i], exp_seq[i]);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        // Write to x0 with Tick stalled mid-write
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = $urandom;
        cycle();
        Tick = 1'b0;
        repeat (4) cycle();
        check_val("t4_busy_held", busy, 1);
        check_val("t4_no_ready", bus.req1_ready, 0);
        Tick = 1'b1;
        #1;
        check_val("t4_ready", bus.req1_ready, 1);
        check_val("t4_x0_wr_en", bus.wr_en, 0);
        cycle();
        bus.req1_valid = 1'b0;
        cycle();

`ifdef REGCTRL_CLEAR_SWEEP_EN
        // Clear sweep takes priority over a pending request
        clear_req = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd9; bus.req0_data = $urandom;
        cycle();
        clear_req = 1'b0;
        for (int i = 1; i < NR; i++) begin
            walk = NR'(1) << i;
            check_val("t5_walk", bus.wr_en, walk);
            check_val("t5_req0_wait", bus.req0_ready, 0);
            cycle();
        end
        cycle();
        check_val("t5_served", bus.req0_ready, 1);
        cycle();
        bus.req0_valid = 1'b0;

        // Reset part-way through a sweep, then restart from x1
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        repeat (11) cycle();
        check_val("t6_ptr12", bus.wr_en, 32'h0000_1000);
        Reset = 1'b1; Tick = 1'b0;
        cycle();
        Reset = 1'b0; Tick = 1'b1;
        #1;
        check_val("t6_idle_wr_en", bus.wr_en, 0);
        check_val("t6_idle_busy", busy, 0);
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        check_val("t6_restart", bus.wr_en, 32'h0000_0002);
        repeat (NR) cycle();
`endif

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            Reset     = ($urandom_range(0, 99) == 0);
            Tick      = Reset ? 1'b0 : ($urandom_range(0, 3) != 0);
            clear_req = ($urandom_range(0, 29) == 0);
            if (!bus.req0_valid && $urandom_range(0, 1) == 1) begin
                bus.req0_valid = 1'b1;
                bus.req0_addr  = AB'($urandom_range(0, NR - 1));
                bus.req0_data  = $urandom;
            end
            if (!bus.req1_valid && $urandom_range(0, 1) == 1) begin
                bus.req1_valid = 1'b1;
                bus.req1_addr  = AB'($urandom_range(0, NR - 1));
                bus.req1_data  = $urandom;
            end
            cycle();
            if (got0) bus.req0_valid = 1'b0;
            if (got1) bus.req1_valid = 1'b0;
        end

        // Drain and compare the bank contents seen on the write bus
        Reset = 1'b0; Tick = 1'b1; clear_req = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (NR + 2) cycle();
        for (int i = 0; i < NR; i++)
            check_val($sformatf("bank_x%0d", i), seen_bank[i], exp_bank[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
